kfps2kb_host_transmitter: RTL and testbench

- Host-to-device PS/2 transmitter; sends command bytes to the keyboard, e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable.
- Opposite direction of the existing PS/2 keyboard receiver. Shares the device_clock/device_data open-collector lines with it.
- Implements the full PS/2 host-send sequence: clock inhibit, request-to-send, 11-clock device-driven frame, ACK check.
- Asserts busy so the receiver path can suppress decoding during a transmission.

---
 rtl/kfps2kb_pkg.sv | 25 ++
 rtl/kfps2kb_line_sync.sv | 35 +++
 rtl/kfps2kb_host_transmitter.sv | 139 +++++++++++++
 tb/tb_kfps2kb_host_transmitter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kfps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard host-side blocks.
package kfps2kb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK_WAIT,
    RELEASE_WAIT
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  localparam logic [3:0] FRAME_EDGES = 4'd11;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/kfps2kb_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a registered
// falling-edge pulse on the clock line; shared with the receiver path.
module kfps2kb_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic clock_in,
  input  logic data_in,
  output logic clock_sync,
  output logic data_sync,
  output logic clock_fall
);

  logic [1:0] clock_ff;
  logic [1:0] data_ff;
  logic       clock_prev;

  // Lines idle high, so reset the chains to 1 to avoid a spurious edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clock_ff   <= 2'b11;
      data_ff    <= 2'b11;
      clock_prev <= 1'b1;
      clock_fall <= 1'b0;
    end else begin
      clock_ff   <= {clock_ff[0], clock_in};
      data_ff    <= {data_ff[0], data_in};
      clock_prev <= clock_ff[1];
      clock_fall <= clock_prev & ~clock_ff[1];
    end
  end

  assign clock_sync = clock_ff[1];
  assign data_sync  = data_ff[1];

endmodule

// File: rtl/kfps2kb_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// 11-edge frame, ACK check, and release wait, with first-edge/bit timeouts.
module kfps2kb_host_transmitter
  import kfps2kb_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES     = 16'd5000,
  parameter logic [19:0] FIRST_EDGE_TIMEOUT = 20'd750000,
  parameter logic [19:0] BIT_TIMEOUT        = 20'd100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock_in,
  input  logic       device_data_in,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  state_t      state, state_next;
  logic [19:0] count;
  logic [3:0]  edge_count;
  logic [8:0]  frame_q;
  logic        drive_q;
  logic        clock_sync, data_sync, clock_fall;
  logic        device_edge, timeout, inhibit_last;

  kfps2kb_line_sync u_line_sync (
    .clock      (clock),
    .reset      (reset),
    .clock_in   (device_clock_in),
    .data_in    (device_data_in),
    .clock_sync (clock_sync),
    .data_sync  (data_sync),
    .clock_fall (clock_fall)
  );

  // Our own inhibit pulls the clock low too, so only count edges once released.
  assign device_edge  = clock_fall &&
                        (state == REQUEST || state == SEND || state == RELEASE_WAIT);
  assign timeout      = !device_edge &&
                        (count >= ((state == REQUEST) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT));
  assign inhibit_last = (count == {4'd0, INHIBIT_CYCLES - 16'd1});

  always_comb begin
    state_next      = state;
    device_clock_oe = 1'b0;
    device_data_oe  = 1'b0;
    tx_done         = 1'b0;
    tx_error        = 1'b0;
    case (state)
      IDLE: if (tx_valid) state_next = INHIBIT;
      INHIBIT: begin
        device_clock_oe = 1'b1;
        if (inhibit_last) begin
          device_data_oe = 1'b1;
          state_next     = REQUEST;
        end
      end
      REQUEST: begin
        device_data_oe = !timeout;
        if (device_edge) state_next = SEND;
        else if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end
      end
      SEND: begin
        device_data_oe = drive_q && !timeout;
        if (device_edge && edge_count == FRAME_EDGES - 4'd1) state_next = ACK_WAIT;
        else if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end
      end
      ACK_WAIT: begin
        if (!data_sync) state_next = RELEASE_WAIT;
        else begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end
      end
      RELEASE_WAIT: begin
        if (clock_sync && data_sync) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          tx_error   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One shared counter: inhibit length, then time since entry or last edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || device_edge) count <= '0;
      else if (count != '1) count <= count + 20'd1;
    end
  end

  // frame_q is {parity, data}; edge n drives frame bit n-1, edge 10 releases.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_count <= '0;
      frame_q    <= '0;
      drive_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          edge_count <= '0;
          drive_q    <= 1'b0;
          if (tx_valid) frame_q <= {odd_parity(tx_data), tx_data};
        end
        REQUEST, SEND: begin
          if (device_edge) begin
            edge_count <= edge_count + 4'd1;
            drive_q    <= (edge_count < 4'd9) ? ~frame_q[edge_count] : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_kfps2kb_host_transmitter.sv
// Self-checking bench: behavioural PS/2 device on open-collector lines and a
// frame/timing reference model computed from the protocol rules.
module tb_kfps2kb_host_transmitter;
  import kfps2kb_pkg::*;

  localparam int INHIBIT  = 20;
  localparam int FIRST_TO = 200;
  localparam int BIT_TO   = 50;
  localparam int HALF     = 10;
  localparam int SYNC_LAT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       device_clock_in, device_data_in;
  logic       device_clock_oe, device_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;

  int         cycle = 0;
  int         run_len = 0, inhibit_len = 0, req_cycle = -1;
  int         done_total = 0, err_total = 0, err_cycle = -1;
  logic [1:0] err_oe = 2'b00;
  int         passed = 0, total = 0;

  always #5 clock = ~clock;

  assign device_clock_in = dev_clk & ~device_clock_oe;
  assign device_data_in  = dev_dat & ~device_data_oe;

  kfps2kb_host_transmitter #(
    .INHIBIT_CYCLES     (16'd20),
    .FIRST_EDGE_TIMEOUT (20'd200),
    .BIT_TIMEOUT        (20'd50)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .device_clock_in (device_clock_in),
    .device_data_in  (device_data_in),
    .device_clock_oe (device_clock_oe),
    .device_data_oe  (device_data_oe),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .tx_done         (tx_done),
    .tx_error        (tx_error)
  );

  always @(posedge clock) cycle <= cycle + 1;

  // Passive monitor of inhibit length, request entry and result pulses.
  always @(negedge clock) begin
    if (device_clock_oe) run_len <= run_len + 1;
    else if (run_len != 0) begin
      inhibit_len <= run_len;
      req_cycle   <= cycle;
      run_len     <= 0;
    end
    if (tx_done) done_total <= done_total + 1;
    if (tx_error) begin
      err_total <= err_total + 1;
      err_cycle <= cycle;
      err_oe    <= {device_clock_oe, device_data_oe};
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Start bit, 8 data bits LSB first, odd parity, stop, then the ACK slot.
  function automatic logic [11:0] expectFrame(input logic [7:0] b, input bit ack);
    int ones = 0;
    logic [11:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    f[11] = ack ? 1'b0 : 1'b1;
    return f;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    while (!tx_ready && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("tx_ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device side: waits for request-to-send, then clocks out up to n edges.
  task automatic runDevice(input int edges, input bit ack, output logic [11:0] bits,
                           output int fall_cycle, output bit ok);
    int guard = 0;
    bits = '1;
    fall_cycle = -1;
    while (!device_clock_oe && guard < 500) begin
      tick();
      guard++;
    end
    guard = 0;
    while (device_clock_oe && guard < 500) begin
      tick();
      guard++;
    end
    ok = !device_clock_oe;
    if (ok) begin
      bits[0] = device_data_in;
      repeat ($urandom_range(40, 2)) tick();
      for (int e = 1; e <= edges; e++) begin
        dev_clk    = 1'b0;
        fall_cycle = cycle;
        repeat (HALF) tick();
        dev_clk = 1'b1;
        bits[e] = device_data_in;
        if (e == 10 && ack) dev_dat = 1'b0;
        if (e == 11) begin
          repeat (2) tick();
          dev_dat = 1'b1;
        end
        if (e < edges) repeat (HALF) tick();
      end
    end
  endtask

  task automatic waitResult(input int snap_d, input int snap_e);
    int guard = 0;
    while (done_total == snap_d && err_total == snap_e && guard < 600) begin
      tick();
      guard++;
    end
    repeat (3) tick();
  endtask

  task automatic sendAndCheck(input string tag, input logic [7:0] b);
    logic [11:0] bits;
    int fc, sd, se;
    bit ok;
    sd = done_total;
    se = err_total;
    applyStimulus(b);
    runDevice(11, 1'b1, bits, fc, ok);
    checkOutput({tag, "_rts"}, 32'(ok), 32'd1);
    checkOutput({tag, "_inhibit_len"}, inhibit_len, INHIBIT);
    checkOutput({tag, "_frame"}, 32'(bits), 32'(expectFrame(b, 1'b1)));
    waitResult(sd, se);
    checkOutput({tag, "_done_once"}, done_total - sd, 1);
    checkOutput({tag, "_no_error"}, err_total - se, 0);
    checkOutput({tag, "_ready"}, 32'({tx_ready, busy}), 32'b10);
  endtask

  initial begin
    logic [11:0] bits;
    int fc, sd, se;
    bit ok;

    tick();
    checkOutput("reset_outputs",
                32'({tx_ready, busy, tx_done, tx_error, device_clock_oe, device_data_oe}),
                32'b100000);
    reset = 1'b1;
    repeat (3) tick();

    sendAndCheck("set_leds", CMD_SET_LEDS);
    sendAndCheck("byte01", 8'h01);
    sendAndCheck("byte00", 8'h00);
    sendAndCheck("reset_cmd", CMD_RESET);
    for (int i = 0; i < 4; i++) sendAndCheck("random", 8'($urandom));

    // Device never clocks after the request-to-send.
    sd = done_total;
    se = err_total;
    applyStimulus(CMD_ENABLE);
    waitResult(sd, se);
    checkOutput("noclk_error", err_total - se, 1);
    checkOutput("noclk_no_done", done_total - sd, 0);
    checkOutput("noclk_timing", err_cycle - req_cycle, FIRST_TO);
    checkOutput("noclk_oe", 32'(err_oe), 32'd0);
    checkOutput("noclk_idle", 32'({busy, device_clock_oe, device_data_oe}), 32'd0);

    // Device stalls after edge 5; the bit timer restarts after each seen edge.
    sd = done_total;
    se = err_total;
    applyStimulus(8'($urandom));
    runDevice(5, 1'b1, bits, fc, ok);
    waitResult(sd, se);
    checkOutput("stall_error", err_total - se, 1);
    checkOutput("stall_no_done", done_total - sd, 0);
    checkOutput("stall_timing", err_cycle, fc + SYNC_LAT + 1 + BIT_TO);
    checkOutput("stall_oe", 32'(err_oe), 32'd0);

    // Device leaves data high in the ACK slot.
    sd = done_total;
    se = err_total;
    applyStimulus(8'hA5);
    runDevice(11, 1'b0, bits, fc, ok);
    waitResult(sd, se);
    checkOutput("nack_frame", 32'(bits), 32'(expectFrame(8'hA5, 1'b0)));
    checkOutput("nack_error", err_total - se, 1);
    checkOutput("nack_no_done", done_total - sd, 0);
    checkOutput("nack_idle",
                32'({tx_ready, device_clock_oe, device_data_oe}), 32'b100);

    // Asynchronous reset in the middle of SEND.
    sd = done_total;
    se = err_total;
    applyStimulus(8'h3C);
    runDevice(6, 1'b1, bits, fc, ok);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_async",
                32'({tx_ready, busy, device_clock_oe, device_data_oe}), 32'b1000);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("mid_reset_no_pulse", (done_total - sd) + (err_total - se), 0);

    // tx_valid while busy is ignored; the first byte is the one sent.
    sd = done_total;
    se = err_total;
    applyStimulus(CMD_SET_LEDS);
    repeat (3) tick();
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    runDevice(11, 1'b1, bits, fc, ok);
    checkOutput("busy_pulse_frame", 32'(bits), 32'(expectFrame(CMD_SET_LEDS, 1'b1)));
    waitResult(sd, se);
    repeat (40) tick();
    checkOutput("busy_pulse_done_once", done_total - sd, 1);
    checkOutput("busy_pulse_not_queued", 32'({tx_ready, busy, device_clock_oe}), 32'b100);

    sendAndCheck("after_reset", 8'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
